dtlb: RTL and testbench
=======================

DTLB -- requirements
Module: dtlb

Interface
REQ-001 SHALL have parameter TLBNUM, default 16: number of fully associative entries, power of two, 2..32.
REQ-002 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port flush, input, 1: pipeline flush.
REQ-005 SHALL have port stall, input, `StallBus: stall vector; bits [4] and [5] used.
REQ-006 SHALL have port req_en, input, 1: data access valid this cycle.
REQ-007 SHALL have port req_vaddr, input, 32: data virtual address.
REQ-008 SHALL have port req_we, input, 1: access is a store.
REQ-009 SHALL have port cp0_asid, input, 8: current ASID.
REQ-010 SHALL have ports w_en (1), w_index (log2 TLBNUM), w_vpn2 (19), w_asid (8), w_g (1), w_pfn0/w_pfn1 (20), w_c0/w_c1 (3), w_d0/w_d1 (1), w_v0/w_v1 (1), all inputs: TLBWI/TLBWR entry write.
REQ-011 SHALL have ports p_en (1), p_vpn2 (19), inputs: TLBP probe; p_found (1), p_index (log2 TLBNUM), outputs.
REQ-012 SHALL have ports r_index input, plus r_vpn2, r_asid, r_g, r_pfn0, r_pfn1, r_c0, r_c1, r_d0, r_d1, r_v0, r_v1 outputs: TLBR read.
REQ-013 SHALL have outputs paddr (32), d_refill (1), d_invalid (1), d_modify (1), d_uncached (1), all registered.

Function
REQ-014 Lookup SHALL be one-cycle: request sampled in cycle N, results valid on outputs in cycle N+1.
REQ-015 Addresses 0x8000_0000-0x9FFF_FFFF SHALL be unmapped: paddr = vaddr & 0x1FFF_FFFF, d_uncached=0, no exception flags.
REQ-016 Addresses 0xA000_0000-0xBFFF_FFFF SHALL be unmapped: same paddr mask, d_uncached=1, no exception flags.
REQ-017 All other addresses SHALL be mapped: entry matches when vpn2 == vaddr[31:13] and (g==1 or asid==cp0_asid).
REQ-018 On multiple matches the lowest index SHALL win.
REQ-019 Mapped, no match: d_refill=1, d_invalid=0, d_modify=0, paddr=0.
REQ-020 Mapped, match, page selected by vaddr[12] (0 -> even, 1 -> odd), v==0: d_invalid=1, others 0.
REQ-021 Mapped, match, v==1, req_we==1, d==0: d_modify=1, others 0.
REQ-022 Mapped valid hit: paddr = {pfn[19:0], vaddr[11:0]}, d_uncached = (c==3'd2).
REQ-023 Exception flags SHALL be mutually exclusive and SHALL be 0 whenever req_en==0 at the sample edge.
REQ-024 Output register update priority: flush -> all outputs 0; else stall[4]==Stop and stall[5]==NoStop -> all outputs 0 (bubble); else stall[4]==NoStop -> load new result; else hold.
REQ-025 Write: when w_en==1 the entry at w_index SHALL update at the rising edge; a lookup or probe sampled in the same cycle SHALL see pre-write contents.
REQ-026 Write SHALL be unaffected by stall and flush.
REQ-027 Probe: p_found/p_index registered, one-cycle, match rule per REQ-017 with cp0_asid, lowest index; p_found=0 gives p_index=0; hold when p_en==0.
REQ-028 Read: r_* outputs SHALL be combinational from the entry at r_index.

Reset
REQ-029 rst low SHALL asynchronously clear all entries (every field 0), paddr, all flags, p_found, p_index.
REQ-030 Reset asserted mid-write SHALL leave that entry cleared; first lookup after release SHALL see the cleared array.

Verification
REQ-031 vaddr 0x8000_1234 load -> next cycle paddr=0x0000_1234, d_uncached=0, all flags 0; vaddr 0xA000_0010 -> paddr=0x0000_0010, d_uncached=1.
REQ-032 Write idx 3: vpn2=0x00001, asid=5, g=0, pfn1=0x12345, v1=1, d1=0, c1=3; cp0_asid=5, store to 0x0000_3ABC -> d_modify=1; load same address -> paddr=0x1234_5ABC, flags 0, d_uncached=0.
REQ-033 Same entry, cp0_asid=6, load 0x0000_3ABC -> d_refill=1; load 0x0000_2000 with v0=0 and cp0_asid=5 -> d_invalid=1.
REQ-034 Identical matching vpn2 in idx 2 and idx 7 -> probe returns p_found=1, p_index=2; lookup uses idx 2 PFN.
REQ-035 Write and lookup same cycle to same vpn2 on an empty array -> d_refill=1; repeat next cycle -> hit.
REQ-036 stall[4]=Stop, stall[5]=NoStop with refill pending -> outputs 0; both Stop -> outputs hold; flush -> outputs 0; rst low mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/dtlb.sv
// Fully associative data TLB with one-cycle registered lookup and probe.
// It also provides combinational entry read-back and async active-low clear of all state.
`ifndef StallBus
`define StallBus 5:0
`endif

module dtlb #(
    parameter int TLBNUM = 16,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [`StallBus] stall,
    input  logic            req_en,
    input  logic [31:0]     req_vaddr,
    input  logic            req_we,
    input  logic [7:0]      cp0_asid,
    input  logic            w_en,
    input  logic [IW-1:0]   w_index,
    input  logic [18:0]     w_vpn2,
    input  logic [7:0]      w_asid,
    input  logic            w_g,
    input  logic [19:0]     w_pfn0,
    input  logic [19:0]     w_pfn1,
    input  logic [2:0]      w_c0,
    input  logic [2:0]      w_c1,
    input  logic            w_d0,
    input  logic            w_d1,
    input  logic            w_v0,
    input  logic            w_v1,
    input  logic            p_en,
    input  logic [18:0]     p_vpn2,
    output logic            p_found,
    output logic [IW-1:0]   p_index,
    input  logic [IW-1:0]   r_index,
    output logic [18:0]     r_vpn2,
    output logic [7:0]      r_asid,
    output logic            r_g,
    output logic [19:0]     r_pfn0,
    output logic [19:0]     r_pfn1,
    output logic [2:0]      r_c0,
    output logic [2:0]      r_c1,
    output logic            r_d0,
    output logic            r_d1,
    output logic            r_v0,
    output logic            r_v1,
    output logic [31:0]     paddr,
    output logic            d_refill,
    output logic            d_invalid,
    output logic            d_modify,
    output logic            d_uncached
);
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [19:0] pfn1;
        logic [2:0]  c0;
        logic [2:0]  c1;
        logic        d0;
        logic        d1;
        logic        v0;
        logic        v1;
    } tlb_entry_t;

    tlb_entry_t tlb_reg [TLBNUM];

    logic [TLBNUM-1:0] lk_match;
    logic [TLBNUM-1:0] pr_match;
    logic [IW-1:0]     lk_idx;
    logic [IW-1:0]     pr_idx;
    logic              lk_hit;
    logic              pr_hit;

    logic [31:0] paddr_next;
    logic        refill_next;
    logic        invalid_next;
    logic        modify_next;
    logic        uncached_next;

    logic [31:0] paddr_reg;
    logic        refill_reg;
    logic        invalid_reg;
    logic        modify_reg;
    logic        uncached_reg;
    logic        p_found_reg;
    logic [IW-1:0] p_index_reg;

    logic unused_stall;
    assign unused_stall = ^stall[3:0];

    for (genvar gi = 0; gi < TLBNUM; gi++) begin : g_match
        assign lk_match[gi] = (tlb_reg[gi].vpn2 == req_vaddr[31:13]) &&
                              (tlb_reg[gi].g || (tlb_reg[gi].asid == cp0_asid));
        assign pr_match[gi] = (tlb_reg[gi].vpn2 == p_vpn2) &&
                              (tlb_reg[gi].g || (tlb_reg[gi].asid == cp0_asid));
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        lk_idx = '0;
        pr_idx = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (lk_match[i]) lk_idx = IW'(i);
            if (pr_match[i]) pr_idx = IW'(i);
        end
        lk_hit = |lk_match;
        pr_hit = |pr_match;
    end

    always_comb begin
        logic        odd;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
        odd           = req_vaddr[12];
        pfn           = odd ? tlb_reg[lk_idx].pfn1 : tlb_reg[lk_idx].pfn0;
        c             = odd ? tlb_reg[lk_idx].c1   : tlb_reg[lk_idx].c0;
        d             = odd ? tlb_reg[lk_idx].d1   : tlb_reg[lk_idx].d0;
        v             = odd ? tlb_reg[lk_idx].v1   : tlb_reg[lk_idx].v0;
        paddr_next    = '0;
        refill_next   = 1'b0;
        invalid_next  = 1'b0;
        modify_next   = 1'b0;
        uncached_next = 1'b0;
        // An idle request produces an all-zero result, including paddr.
        if (req_en) begin
            if (req_vaddr[31:30] == 2'b10) begin
                paddr_next    = {3'b000, req_vaddr[28:0]};
                uncached_next = req_vaddr[29];
            end else if (!lk_hit) begin
                refill_next = 1'b1;
            end else if (!v) begin
                invalid_next = 1'b1;
            end else if (req_we && !d) begin
                modify_next = 1'b1;
            end else begin
                paddr_next    = {pfn, req_vaddr[11:0]};
                uncached_next = (c == 3'd2);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TLBNUM; i++) tlb_reg[i] <= '0;
        end else if (w_en) begin
            tlb_reg[w_index] <= '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                                  pfn0: w_pfn0, pfn1: w_pfn1, c0: w_c0, c1: w_c1,
                                  d0: w_d0, d1: w_d1, v0: w_v0, v1: w_v1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            paddr_reg    <= '0;
            refill_reg   <= 1'b0;
            invalid_reg  <= 1'b0;
            modify_reg   <= 1'b0;
            uncached_reg <= 1'b0;
        end else if (flush || (stall[4] == STOP && stall[5] == NO_STOP)) begin
            paddr_reg    <= '0;
            refill_reg   <= 1'b0;
            invalid_reg  <= 1'b0;
            modify_reg   <= 1'b0;
            uncached_reg <= 1'b0;
        end else if (stall[4] == NO_STOP) begin
            paddr_reg    <= paddr_next;
            refill_reg   <= refill_next;
            invalid_reg  <= invalid_next;
            modify_reg   <= modify_next;
            uncached_reg <= uncached_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_found_reg <= 1'b0;
            p_index_reg <= '0;
        end else if (p_en) begin
            p_found_reg <= pr_hit;
            p_index_reg <= pr_hit ? pr_idx : '0;
        end
    end

    assign paddr      = paddr_reg;
    assign d_refill   = refill_reg;
    assign d_invalid  = invalid_reg;
    assign d_modify   = modify_reg;
    assign d_uncached = uncached_reg;
    assign p_found    = p_found_reg;
    assign p_index    = p_index_reg;

    assign r_vpn2 = tlb_reg[r_index].vpn2;
    assign r_asid = tlb_reg[r_index].asid;
    assign r_g    = tlb_reg[r_index].g;
    assign r_pfn0 = tlb_reg[r_index].pfn0;
    assign r_pfn1 = tlb_reg[r_index].pfn1;
    assign r_c0   = tlb_reg[r_index].c0;
    assign r_c1   = tlb_reg[r_index].c1;
    assign r_d0   = tlb_reg[r_index].d0;
    assign r_d1   = tlb_reg[r_index].d1;
    assign r_v0   = tlb_reg[r_index].v0;
    assign r_v1   = tlb_reg[r_index].v1;

endmodule

// File: tb/tb_dtlb.sv
// Randomized and directed bench for dtlb against a behavioural translation model.
module tb_dtlb;
    localparam int N  = 16;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush;
    logic [5:0] stall;
    logic req_en, req_we;
    logic [31:0] req_vaddr;
    logic [7:0] cp0_asid;
    logic w_en, w_g, w_d0, w_d1, w_v0, w_v1;
    logic [IW-1:0] w_index, p_index, r_index;
    logic [18:0] w_vpn2, p_vpn2, r_vpn2;
    logic [7:0] w_asid, r_asid;
    logic [19:0] w_pfn0, w_pfn1, r_pfn0, r_pfn1;
    logic [2:0] w_c0, w_c1, r_c0, r_c1;
    logic p_en, p_found;
    logic r_g, r_d0, r_d1, r_v0, r_v1;
    logic [31:0] paddr;
    logic d_refill, d_invalid, d_modify, d_uncached;

    always #5 clk = ~clk;

    dtlb #(.TLBNUM(N)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .req_en(req_en), .req_vaddr(req_vaddr), .req_we(req_we), .cp0_asid(cp0_asid),
        .w_en(w_en), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_pfn1(w_pfn1), .w_c0(w_c0), .w_c1(w_c1),
        .w_d0(w_d0), .w_d1(w_d1), .w_v0(w_v0), .w_v1(w_v1),
        .p_en(p_en), .p_vpn2(p_vpn2), .p_found(p_found), .p_index(p_index),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_pfn1(r_pfn1), .r_c0(r_c0), .r_c1(r_c1),
        .r_d0(r_d0), .r_d1(r_d1), .r_v0(r_v0), .r_v1(r_v1),
        .paddr(paddr), .d_refill(d_refill), .d_invalid(d_invalid),
        .d_modify(d_modify), .d_uncached(d_uncached)
    );

    typedef struct {
        int unsigned vpn2, asid, g, pfn0, pfn1, c0, c1, d0, d1, v0, v1;
    } ent_t;

    ent_t model [N];
    int checks = 0;
    int errors = 0;
    logic [31:0] e_paddr;
    logic e_ref, e_inv, e_mod, e_unc, e_pf;
    logic [IW-1:0] e_pi;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_match(input int unsigned vpn2, input int unsigned asid);
        for (int i = 0; i < N; i++)
            if (model[i].vpn2 == vpn2 && (model[i].g == 1 || model[i].asid == asid)) return i;
        return -1;
    endfunction

    function automatic void ref_lookup(input logic en, input logic [31:0] va, input logic we,
                                       input logic [7:0] asid, output logic [31:0] pa,
                                       output logic rf, output logic inv, output logic md,
                                       output logic un);
        int hit;
        int unsigned pfn, c, d, v;
        pa = 0; rf = 0; inv = 0; md = 0; un = 0;
        if (!en) return;
        if (va >= 32'h8000_0000 && va <= 32'h9FFF_FFFF) begin pa = va - 32'h8000_0000; return; end
        if (va >= 32'hA000_0000 && va <= 32'hBFFF_FFFF) begin pa = va - 32'hA000_0000; un = 1; return; end
        hit = ref_match(va / 8192, asid);
        if (hit < 0) begin rf = 1; return; end
        if ((va / 4096) % 2 == 1) begin
            pfn = model[hit].pfn1; c = model[hit].c1; d = model[hit].d1; v = model[hit].v1;
        end else begin
            pfn = model[hit].pfn0; c = model[hit].c0; d = model[hit].d0; v = model[hit].v0;
        end
        if (v == 0) inv = 1;
        else if (we && d == 0) md = 1;
        else begin pa = pfn * 4096 + va % 4096; un = (c == 2); end
    endfunction

    task automatic clear_model();
        for (int i = 0; i < N; i++) model[i] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        e_paddr = 0; e_ref = 0; e_inv = 0; e_mod = 0; e_unc = 0; e_pf = 0; e_pi = 0;
    endtask

    task automatic step(input string name);
        logic [31:0] pa;
        logic rf, inv, md, un;
        int pi;
        ent_t e;
        ref_lookup(req_en, req_vaddr, req_we, cp0_asid, pa, rf, inv, md, un);
        if (flush || (stall[4] && !stall[5])) begin
            e_paddr = 0; e_ref = 0; e_inv = 0; e_mod = 0; e_unc = 0;
        end else if (!stall[4]) begin
            e_paddr = pa; e_ref = rf; e_inv = inv; e_mod = md; e_unc = un;
        end
        if (p_en) begin
            pi = ref_match(p_vpn2, cp0_asid);
            e_pf = (pi >= 0);
            e_pi = (pi >= 0) ? IW'(pi) : '0;
        end
        @(posedge clk);
        if (w_en)
            model[w_index] = '{w_vpn2, w_asid, w_g, w_pfn0, w_pfn1, w_c0, w_c1, w_d0, w_d1, w_v0, w_v1};
        #1;
        e = model[r_index];
        check("paddr", paddr, e_paddr);
        check("refill", d_refill, e_ref);
        check("invalid", d_invalid, e_inv);
        check("modify", d_modify, e_mod);
        check("uncached", d_uncached, e_unc);
        check("p_found", p_found, e_pf);
        check("p_index", p_index, e_pi);
        check("read_a", {r_vpn2, r_asid, r_g, r_pfn0},
              {e.vpn2[18:0], e.asid[7:0], e.g[0], e.pfn0[19:0]});
        check("read_b", {r_pfn1, r_c0, r_c1, r_d0, r_d1, r_v0, r_v1},
              {e.pfn1[19:0], e.c0[2:0], e.c1[2:0], e.d0[0], e.d1[0], e.v0[0], e.v1[0]});
        $display("txn %s va=%h we=%b asid=%0d paddr=%h rf=%b inv=%b mod=%b unc=%b pf=%b pi=%0d",
                 name, req_vaddr, req_we, cp0_asid, paddr, d_refill, d_invalid, d_modify,
                 d_uncached, p_found, p_index);
        @(negedge clk);
    endtask

    task automatic wr(input logic [IW-1:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                      input logic g, input logic [19:0] pfn0, input logic [19:0] pfn1,
                      input logic [2:0] c0, input logic [2:0] c1, input logic d0, input logic d1,
                      input logic v0, input logic v1);
        w_en = 1; w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
        w_pfn0 = pfn0; w_pfn1 = pfn1; w_c0 = c0; w_c1 = c1;
        w_d0 = d0; w_d1 = d1; w_v0 = v0; w_v1 = v1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pa"}, paddr, 0);
        check({tag, "_flags"}, {d_refill, d_invalid, d_modify, d_uncached}, 0);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout got=running exp=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        flush = 0; stall = 0; req_en = 0; req_we = 0; req_vaddr = 0; cp0_asid = 0;
        w_en = 0; w_index = 0; w_vpn2 = 0; w_asid = 0; w_g = 0; w_pfn0 = 0; w_pfn1 = 0;
        w_c0 = 0; w_c1 = 0; w_d0 = 0; w_d1 = 0; w_v0 = 0; w_v1 = 0;
        p_en = 0; p_vpn2 = 0; r_index = 0;
        clear_model();
        #1 rst = 0;
        repeat (2) @(negedge clk);
        check_outputs_zero("rst");
        check("rst_probe", {p_found, p_index}, 0);
        check("rst_read", {r_vpn2, r_pfn0, r_v0}, 0);
        rst = 1;
        @(negedge clk);

        req_en = 1; req_vaddr = 32'h8000_1234;
        step("kseg0");
        check("kseg0_pa", paddr, 32'h0000_1234);
        check("kseg0_unc", d_uncached, 0);
        req_vaddr = 32'hA000_0010;
        step("kseg1");
        check("kseg1_pa", paddr, 32'h0000_0010);
        check("kseg1_unc", d_uncached, 1);

        wr(3, 19'h1, 8'd5, 0, 20'h0, 20'h12345, 3'd0, 3'd3, 0, 0, 0, 1);
        req_en = 0; r_index = 3;
        step("wr3");
        w_en = 0;
        cp0_asid = 5; req_en = 1; req_we = 1; req_vaddr = 32'h0000_3ABC;
        step("store_clean");
        check("modify_hit", d_modify, 1);
        req_we = 0;
        step("load_hit");
        check("hit_pa", paddr, 32'h1234_5ABC);
        check("hit_flags", {d_refill, d_invalid, d_modify, d_uncached}, 0);
        cp0_asid = 6;
        step("asid_miss");
        check("asid_refill", d_refill, 1);
        cp0_asid = 5; req_vaddr = 32'h0000_2000;
        step("even_invalid");
        check("even_inv", d_invalid, 1);

        wr(2, 19'h40, 8'd0, 1, 20'hAAAAA, 20'h0, 3'd3, 3'd0, 1, 0, 1, 0);
        req_en = 0;
        step("wr2");
        wr(7, 19'h40, 8'd0, 1, 20'hBBBBB, 20'h0, 3'd2, 3'd0, 1, 0, 1, 0);
        step("wr7");
        w_en = 0;
        p_en = 1; p_vpn2 = 19'h40; req_en = 1; req_vaddr = 32'h0008_0100;
        step("multi");
        check("multi_pf", p_found, 1);
        check("multi_pi", p_index, 2);
        check("multi_pa", paddr, 32'hAAAA_A100);
        p_vpn2 = 19'h123;
        step("probe_miss");
        check("pmiss", {p_found, p_index}, 0);
        p_en = 0;

        req_vaddr = 32'h0050_0000;
        step("refill");
        check("refill_set", d_refill, 1);
        stall = 6'b010000;
        step("bubble");
        check_outputs_zero("bubble");
        stall = 6'b000000;
        step("refill2");
        stall = 6'b110000; req_vaddr = 32'h8000_0040;
        step("hold");
        check("hold_refill", d_refill, 1);
        stall = 6'b000000; flush = 1;
        step("flush");
        check_outputs_zero("flush");
        flush = 0; req_vaddr = 32'h0050_0000; p_en = 1; p_vpn2 = 19'h40;
        step("refill3");
        p_en = 0;

        wr(3, 19'h7, 8'd1, 1, 20'h11111, 20'h22222, 3'd1, 3'd1, 1, 1, 1, 1);
        #2 rst = 0;
        #1;
        check_outputs_zero("async_rst");
        check("async_probe", {p_found, p_index}, 0);
        r_index = 3;
        @(posedge clk);
        @(negedge clk);
        w_en = 0; rst = 1;
        clear_model();
        #1;
        check("rst_write_read", {r_vpn2, r_pfn1, r_v1}, 0);

        wr(0, 19'h10, 8'd0, 1, 20'h55555, 20'h0, 3'd3, 3'd0, 1, 0, 1, 0);
        req_en = 1; req_we = 0; req_vaddr = 32'h0002_0000;
        step("wr_same_cycle");
        check("same_cycle_refill", d_refill, 1);
        w_en = 0;
        step("after_wr");
        check("after_wr_pa", paddr, 32'h5555_5000);

        for (int k = 0; k < 400; k++) begin
            flush = ($urandom % 16 == 0);
            stall = {1'($urandom % 4 == 0), 1'($urandom % 4 == 0), 4'($urandom)};
            w_en = ($urandom % 3 == 0);
            w_index = IW'($urandom); w_vpn2 = 19'($urandom % 8); w_asid = 8'($urandom % 4);
            w_g = ($urandom % 4 == 0); w_pfn0 = 20'($urandom); w_pfn1 = 20'($urandom);
            w_c0 = 3'($urandom); w_c1 = 3'($urandom);
            w_d0 = 1'($urandom); w_d1 = 1'($urandom); w_v0 = ($urandom % 4 != 0); w_v1 = ($urandom % 4 != 0);
            req_en = ($urandom % 4 != 0); req_we = 1'($urandom);
            if ($urandom % 8 == 0) req_vaddr = $urandom;
            else req_vaddr = {19'($urandom % 8), 13'($urandom)};
            cp0_asid = 8'($urandom % 4);
            p_en = 1'($urandom); p_vpn2 = 19'($urandom % 8);
            r_index = IW'($urandom);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
